dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port (scalar/vector select, one access per cycle) between the scalar load/store unit and the vector load/store unit.
- Each requester has a valid/ready request channel and a read-response channel.
- Arbitration is round-robin on single beats. Vector bursts are locked, with a bounded yield to pending scalar traffic.
- Sits between both LSUs and dmem, and drives every dmem input directly.

Parameters:
- ADDR_W, 32, byte address width.
- SDATA_W, 16, scalar data width (dmem port a).
- VDATA_W, 256, vector data width (dmem port b).
- MAX_BURST, 8, vector beats granted back-to-back before a pending scalar request forces a one-beat yield (must be >= 1).
- RD_LAT, 1, dmem read latency in cycles from address edge to q valid (must be >= 1).

Ports:
- clk  in  1  clock; everything sampled on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_req_valid  in  1  scalar request valid.
- s_req_ready  out  1  scalar request accepted this cycle.
- s_req_we  in  1  1 = write, 0 = read.
- s_req_addr  in  ADDR_W  scalar address.
- s_req_wdata  in  SDATA_W  scalar write data.
- s_rsp_valid  out  1  scalar read data valid.
- s_rsp_rdata  out  SDATA_W  scalar read data.
- v_req_valid  in  1  vector request valid.
- v_req_ready  out  1  vector request accepted.
- v_req_we  in  1  vector write.
- v_req_last  in  1  final beat of a vector burst (1 on single-beat accesses).
- v_req_addr  in  ADDR_W  vector address.
- v_req_wdata  in  VDATA_W  vector write data.
- v_rsp_valid  out  1  vector read data valid.
- v_rsp_rdata  out  VDATA_W  vector read data.
- mem_w_enable  out  1  to dmem w_enable.
- mem_src_sel  out  1  to dmem src_sel (0 scalar, 1 vector).
- mem_addr  out  ADDR_W  to dmem addr.
- mem_w_data_a  out  SDATA_W  to dmem w_data_a.
- mem_w_data_b  out  VDATA_W  to dmem w_data_b.
- mem_q_a  in  SDATA_W  from dmem q_a.
- mem_q_b  in  VDATA_W  from dmem q_b.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values, and values while rst_n = 0:
  - s_req_ready, v_req_ready, s_rsp_valid, v_rsp_valid, mem_w_enable, mem_src_sel = 0.
  - mem_addr and all data buses = 0.
  - State IDLE, last_grant = vector (so scalar wins the first conflict), burst counter = 0.
- Handshake:
  - A beat is accepted when req_valid && req_ready.
  - Ready is combinational from state, last_grant and both valids; at most one ready is high per cycle.
  - Requesters hold addr/we/wdata/valid stable until accepted.
- Memory drive:
  - In the accept cycle, mem_* is driven combinationally from the granted requester.
  - mem_w_enable = accepted && we.
  - mem_src_sel = 1 iff the vector is granted.
  - The data bus of the non-granted width is driven to 0.
  - With no grant: mem_w_enable = 0, mem_src_sel = 0, mem_addr = 0.
- Read response:
  - An accepted read pushes {valid, owner} into an RD_LAT-deep shift pipe.
  - Exactly RD_LAT cycles after acceptance, the owner's rsp_valid is high for one cycle, with rdata = mem_q_a (scalar) or mem_q_b (vector).
  - Writes produce no response.
  - rsp_rdata = 0 whenever rsp_valid = 0.
- FSM:
  - IDLE:
    - only s valid -> grant scalar;
    - only v valid -> grant vector;
    - both valid -> grant the one not equal to last_grant.
    - Vector granted with v_req_last = 0 -> VBURST, counter = 1.
    - Each grant updates last_grant.
  - VBURST:
    - Only the vector may be granted.
    - Each accepted vector beat increments the counter.
    - Accepted beat with v_req_last = 1 -> IDLE, counter = 0.
    - Counter == MAX_BURST and s_req_valid -> YIELD, counter = 0.
    - Counter == MAX_BURST and no scalar pending -> the burst continues and the counter holds.
    - v_req_valid low inside a burst -> stall in VBURST with no grant.
  - YIELD:
    - Scalar granted for exactly one beat -> VBURST.
    - If s_req_valid drops before acceptance -> VBURST with no grant.
- Simultaneous events: scalar and vector valid in the same IDLE cycle resolve by round-robin only; there is no fixed priority.
- Reset mid-operation: in-flight response pipe entries are discarded and no rsp_valid appears after release. A partial burst is abandoned (state IDLE).
- Back-to-back: one accepted beat per cycle is sustainable; there are no bubbles between grants.

Decomposition:
- dmem_pkg holds:
  - typedef arb_state_t {IDLE, VBURST, YIELD};
  - owner enum {OWN_S = 0, OWN_V = 1};
  - default width constants SDATA_W = 16, VDATA_W = 256, ADDR_W = 32.
- One natural sub-module: dmem_rsp_pipe (RD_LAT-deep valid/owner shift register with async reset), instantiated once.

Test Plan:
- Scalar write then read: s write addr 0x10 data 0xFFFF, next cycle s read 0x10.
  - Write cycle: mem_w_enable = 1, mem_src_sel = 0.
  - Read: s_rsp_valid one cycle after accept, s_rsp_rdata = 0xFFFF; v_rsp_valid stays 0.
- Simultaneous single beats: both valid from reset, reads at 0x10 (s) and 0x20 (v).
  - Grant order: scalar, then vector.
  - Responses arrive on consecutive cycles to the correct owners.
- Vector burst of 4 (last on beat 4), addresses 0x20/0x40/0x60/0x80, vector writes 0xAAAA…: v_req_ready high 4 consecutive cycles, mem_src_sel = 1 throughout; a scalar request arriving on beat 2 is granted on the cycle after beat 4.
- Starvation bound: MAX_BURST = 8, 20-beat vector burst, scalar valid from beat 1: scalar granted at cycle 9 exactly, vector resumes at cycle 10, v_rsp_valid order preserved.
- Reset mid-burst: assert rst_n = 0 asynchronously two cycles into a read burst with responses in flight.
  - All outputs are 0 immediately.
  - After release, no stray rsp_valid; state IDLE, and the first conflict goes to scalar.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default widths for the data-memory arbiter
// Contents: arbiter state encoding, response owner encoding, default bus widths.
package dmem_pkg;

    localparam int ADDR_W  = 32;
    localparam int SDATA_W = 16;
    localparam int VDATA_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBURST = 2'd1,
        YIELD  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_S = 1'b0,
        OWN_V = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// rtl/dmem_rsp_pipe.sv - read-response tracking shift register (valid + owner)
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push_valid, push_owner  accepted read entering the pipe this cycle
//   pop_valid, pop_owner    read whose data is on dmem q this cycle
module dmem_rsp_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  dmem_pkg::owner_t  push_owner,
    output logic              pop_valid,
    output dmem_pkg::owner_t  pop_owner
);
    import dmem_pkg::*;

    logic [RD_LAT-1:0] vld_q;
    owner_t            own_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                own_q[i] <= OWN_S;
            end
        end else begin
            vld_q[0] <= push_valid;
            own_q[0] <= push_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign pop_valid = vld_q[RD_LAT-1];
    assign pop_owner = own_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one dmem port between the scalar and vector LSUs
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_req_* / s_rsp_*               scalar request channel and read response
//   v_req_* / v_rsp_*               vector request channel (bursts via v_req_last) and read response
//   mem_w_enable .. mem_w_data_b    dmem inputs, driven combinationally from the granted requester
//   mem_q_a, mem_q_b                dmem read data, valid RD_LAT cycles after the address
module dmem_arbiter #(
    parameter int ADDR_W    = dmem_pkg::ADDR_W,
    parameter int SDATA_W   = dmem_pkg::SDATA_W,
    parameter int VDATA_W   = dmem_pkg::VDATA_W,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_req_valid,
    output logic               s_req_ready,
    input  logic               s_req_we,
    input  logic [ADDR_W-1:0]  s_req_addr,
    input  logic [SDATA_W-1:0] s_req_wdata,
    output logic               s_rsp_valid,
    output logic [SDATA_W-1:0] s_rsp_rdata,
    input  logic               v_req_valid,
    output logic               v_req_ready,
    input  logic               v_req_we,
    input  logic               v_req_last,
    input  logic [ADDR_W-1:0]  v_req_addr,
    input  logic [VDATA_W-1:0] v_req_wdata,
    output logic               v_rsp_valid,
    output logic [VDATA_W-1:0] v_rsp_rdata,
    output logic               mem_w_enable,
    output logic               mem_src_sel,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [SDATA_W-1:0] mem_w_data_a,
    output logic [VDATA_W-1:0] mem_w_data_b,
    input  logic [SDATA_W-1:0] mem_q_a,
    input  logic [VDATA_W-1:0] mem_q_b
);
    import dmem_pkg::*;

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             s_gnt, v_gnt;
    logic             acc_s, acc_v;
    logic             rsp_vld;
    owner_t           rsp_own;

    // Count saturates at MAX_BURST so an unchallenged long burst simply holds there.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        s_gnt   = 1'b0;
        v_gnt   = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (s_req_valid && (!v_req_valid || last_q == OWN_V)) begin
                    s_gnt = 1'b1;
                end else if (v_req_valid) begin
                    v_gnt = 1'b1;
                    if (!v_req_last) begin
                        if (CNT_ONE == CNT_MAX && s_req_valid) begin
                            state_d = YIELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = VBURST;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
            end
            VBURST: begin
                // A saturated burst that sees scalar traffic arrive gives up this cycle.
                if (cnt_q == CNT_MAX && s_req_valid) begin
                    state_d = YIELD;
                    cnt_d   = '0;
                end else if (v_req_valid) begin
                    v_gnt = 1'b1;
                    if (v_req_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_MAX && s_req_valid) begin
                        // Yield right after the MAX_BURST-th beat so the scalar gets the next slot.
                        state_d = YIELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            YIELD: begin
                state_d = VBURST;
                s_gnt   = s_req_valid;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (s_gnt) last_d = OWN_S;
        if (v_gnt) last_d = OWN_V;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= OWN_V;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants are masked by reset so every output reads 0 while rst_n is low.
    assign acc_s = s_gnt && rst_n;
    assign acc_v = v_gnt && rst_n;

    assign s_req_ready  = acc_s;
    assign v_req_ready  = acc_v;
    assign mem_w_enable = (acc_s && s_req_we) || (acc_v && v_req_we);
    assign mem_src_sel  = acc_v;
    assign mem_addr     = acc_s ? s_req_addr : (acc_v ? v_req_addr : '0);
    assign mem_w_data_a = acc_s ? s_req_wdata : '0;
    assign mem_w_data_b = acc_v ? v_req_wdata : '0;

    dmem_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid ((acc_s && !s_req_we) || (acc_v && !v_req_we)),
        .push_owner (acc_v ? OWN_V : OWN_S),
        .pop_valid  (rsp_vld),
        .pop_owner  (rsp_own)
    );

    assign s_rsp_valid = rsp_vld && (rsp_own == OWN_S);
    assign v_rsp_valid = rsp_vld && (rsp_own == OWN_V);
    assign s_rsp_rdata = s_rsp_valid ? mem_q_a : '0;
    assign v_rsp_rdata = v_rsp_valid ? mem_q_b : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int SDATA_W   = 16;
    localparam int VDATA_W   = 256;
    localparam int MAX_BURST = 8;
    localparam int RD_LAT    = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_req_valid = 1'b0;
    logic               s_req_ready;
    logic               s_req_we = 1'b0;
    logic [ADDR_W-1:0]  s_req_addr = '0;
    logic [SDATA_W-1:0] s_req_wdata = '0;
    logic               s_rsp_valid;
    logic [SDATA_W-1:0] s_rsp_rdata;
    logic               v_req_valid = 1'b0;
    logic               v_req_ready;
    logic               v_req_we = 1'b0;
    logic               v_req_last = 1'b0;
    logic [ADDR_W-1:0]  v_req_addr = '0;
    logic [VDATA_W-1:0] v_req_wdata = '0;
    logic               v_rsp_valid;
    logic [VDATA_W-1:0] v_rsp_rdata;
    logic               mem_w_enable;
    logic               mem_src_sel;
    logic [ADDR_W-1:0]  mem_addr;
    logic [SDATA_W-1:0] mem_w_data_a;
    logic [VDATA_W-1:0] mem_w_data_b;
    logic [SDATA_W-1:0] mem_q_a = '0;
    logic [VDATA_W-1:0] mem_q_b = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic               own;
        logic [VDATA_W-1:0] data;
        int                 acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [VDATA_W-1:0] got_data;

    logic [SDATA_W-1:0] smem [logic [ADDR_W-1:0]];
    logic [VDATA_W-1:0] vmem [logic [ADDR_W-1:0]];
    logic [SDATA_W-1:0] sh_s [logic [ADDR_W-1:0]];
    logic [VDATA_W-1:0] sh_v [logic [ADDR_W-1:0]];

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .SDATA_W   (SDATA_W),
        .VDATA_W   (VDATA_W),
        .MAX_BURST (MAX_BURST),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_we     (s_req_we),
        .s_req_addr   (s_req_addr),
        .s_req_wdata  (s_req_wdata),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_rdata  (s_rsp_rdata),
        .v_req_valid  (v_req_valid),
        .v_req_ready  (v_req_ready),
        .v_req_we     (v_req_we),
        .v_req_last   (v_req_last),
        .v_req_addr   (v_req_addr),
        .v_req_wdata  (v_req_wdata),
        .v_rsp_valid  (v_rsp_valid),
        .v_rsp_rdata  (v_rsp_rdata),
        .mem_w_enable (mem_w_enable),
        .mem_src_sel  (mem_src_sel),
        .mem_addr     (mem_addr),
        .mem_w_data_a (mem_w_data_a),
        .mem_w_data_b (mem_w_data_b),
        .mem_q_a      (mem_q_a),
        .mem_q_b      (mem_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SDATA_W-1:0] spat(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [VDATA_W-1:0] vpat(input logic [ADDR_W-1:0] a);
        return {8{a ^ 32'hC3C3_0000}};
    endfunction

    function automatic logic any_out();
        return |{s_req_ready, v_req_ready, s_rsp_valid, v_rsp_valid, mem_w_enable, mem_src_sel,
                 mem_addr, mem_w_data_a, mem_w_data_b, s_rsp_rdata, v_rsp_rdata};
    endfunction

    // dmem model, one-cycle read latency, driven only from the mem_* ports
    always @(posedge clk) begin
        if (mem_w_enable && !mem_src_sel) smem[mem_addr] = mem_w_data_a;
        if (mem_w_enable && mem_src_sel)  vmem[mem_addr] = mem_w_data_b;
        mem_q_a <= smem.exists(mem_addr) ? smem[mem_addr] : spat(mem_addr);
        mem_q_b <= vmem.exists(mem_addr) ? vmem[mem_addr] : vpat(mem_addr);
    end

    always @(negedge rst_n) sb.delete();

    // Scoreboard: responses checked against expectations queued at acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((!s_rsp_valid && s_rsp_rdata !== '0) || (!v_rsp_valid && v_rsp_rdata !== '0)) begin
                errors++;
                $display("FAIL rsp_idle_zero s_rdata=%h v_rdata_nonzero=%0b required 0", s_rsp_rdata, |v_rsp_rdata);
            end
            if (s_rsp_valid || v_rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stray_rsp s_valid=%0b v_valid=%0b required no response", s_rsp_valid, v_rsp_valid);
                end else begin
                    e = sb.pop_front();
                    got_data = v_rsp_valid ? v_rsp_rdata : {{(VDATA_W-SDATA_W){1'b0}}, s_rsp_rdata};
                    if ((s_rsp_valid && v_rsp_valid) || v_rsp_valid !== e.own || got_data !== e.data
                        || (cyc - e.acc_cyc) != RD_LAT) begin
                        errors++;
                        $display("FAIL rsp_match owner=%0b data=%h lat=%0d required owner=%0b data=%h lat=%0d",
                                 v_rsp_valid, got_data, cyc - e.acc_cyc, e.own, e.data, RD_LAT);
                    end
                end
            end
            if (s_req_valid && s_req_ready) begin
                if (s_req_we) sh_s[s_req_addr] = s_req_wdata;
                else sb.push_back('{1'b0, {{(VDATA_W-SDATA_W){1'b0}},
                                  sh_s.exists(s_req_addr) ? sh_s[s_req_addr] : spat(s_req_addr)}, cyc});
            end
            if (v_req_valid && v_req_ready) begin
                if (v_req_we) sh_v[v_req_addr] = v_req_wdata;
                else sb.push_back('{1'b1, sh_v.exists(v_req_addr) ? sh_v[v_req_addr] : vpat(v_req_addr), cyc});
            end
        end
    end

    task automatic idle_inputs();
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0; s_req_wdata = '0;
        v_req_valid = 1'b0; v_req_we = 1'b0; v_req_last = 1'b0; v_req_addr = '0; v_req_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_req_valid = 1'b1; s_req_we = 1'b1; s_req_addr = 32'h44; s_req_wdata = 16'h1234;
        v_req_valid = 1'b1; v_req_we = 1'b1; v_req_addr = 32'h80; v_req_wdata = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs some output=1 required all 0");
        end
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle some output=1 required all 0");
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        s_req_valid = 1'b1; s_req_we = 1'b1; s_req_addr = 32'h10; s_req_wdata = 16'hFFFF;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready, mem_w_enable, mem_src_sel, mem_addr, mem_w_data_a} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 16'hFFFF} || mem_w_data_b !== '0) begin
            errors++;
            $display("FAIL s_write_drive rdy=%0b we=%0b sel=%0b addr=%h wa=%h required 1 1 0 10 ffff",
                     s_req_ready, mem_w_enable, mem_src_sel, mem_addr, mem_w_data_a);
        end
        @(posedge clk); #1;
        s_req_we = 1'b0; s_req_wdata = '0;
        @(negedge clk);
        checks++;
        if ({s_req_ready, mem_w_enable, mem_src_sel, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL s_read_drive rdy=%0b we=%0b sel=%0b addr=%h required 1 0 0 10",
                     s_req_ready, mem_w_enable, mem_src_sel, mem_addr);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({s_rsp_valid, v_rsp_valid, s_rsp_rdata} !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL s_read_rsp s_valid=%0b v_valid=%0b rdata=%h required 1 0 ffff",
                     s_rsp_valid, v_rsp_valid, s_rsp_rdata);
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s_req_valid = 1'b1; s_req_addr = 32'h10;
        v_req_valid = 1'b1; v_req_addr = 32'h20; v_req_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready, mem_src_sel} !== 3'b100) begin
            errors++;
            $display("FAIL sim_first s_rdy=%0b v_rdy=%0b sel=%0b required 1 0 0", s_req_ready, v_req_ready, mem_src_sel);
        end
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready, mem_src_sel, mem_addr, s_rsp_valid} !== {3'b011, 32'h20, 1'b1}) begin
            errors++;
            $display("FAIL sim_second s_rdy=%0b v_rdy=%0b sel=%0b addr=%h s_rsp=%0b required 0 1 1 20 1",
                     s_req_ready, v_req_ready, mem_src_sel, mem_addr, s_rsp_valid);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({s_rsp_valid, v_rsp_valid} !== 2'b01) begin
            errors++;
            $display("FAIL sim_v_rsp s_valid=%0b v_valid=%0b required 0 1", s_rsp_valid, v_rsp_valid);
        end
    endtask

    task automatic test_vburst();
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            v_req_valid = 1'b1; v_req_we = 1'b1; v_req_wdata = {16{16'hAAAA}};
            v_req_addr = 32'h20 + 32'(b) * 32'h20; v_req_last = (b == 3);
            if (b == 1) begin
                s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 32'h10;
            end
            @(negedge clk);
            checks++;
            if ({v_req_ready, s_req_ready, mem_src_sel, mem_w_enable, mem_addr} !== {4'b1011, v_req_addr}
                || mem_w_data_b !== {16{16'hAAAA}} || mem_w_data_a !== '0) begin
                errors++;
                $display("FAIL burst_beat%0d v_rdy=%0b s_rdy=%0b sel=%0b we=%0b addr=%h required 1 0 1 1 %h",
                         b, v_req_ready, s_req_ready, mem_src_sel, mem_w_enable, mem_addr, v_req_addr);
            end
        end
        @(posedge clk); #1;
        v_req_valid = 1'b0; v_req_we = 1'b0; v_req_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready, mem_src_sel} !== 3'b100) begin
            errors++;
            $display("FAIL burst_then_s s_rdy=%0b v_rdy=%0b sel=%0b required 1 0 0", s_req_ready, v_req_ready, mem_src_sel);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_starvation();
        int  b = 0;
        logic s_pend = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk); #1;
            v_req_valid = (b < 20); v_req_we = 1'b0;
            v_req_addr = 32'h100 + 32'(b) * 32'h20; v_req_last = (b == 19);
            s_req_valid = s_pend; s_req_we = 1'b0; s_req_addr = 32'h10;
            @(negedge clk);
            checks++;
            if ({s_req_ready, v_req_ready, mem_src_sel} !== {(c == 9), (c != 9), (c != 9)}) begin
                errors++;
                $display("FAIL starve_cycle%0d s_rdy=%0b v_rdy=%0b sel=%0b required %0b %0b %0b",
                         c, s_req_ready, v_req_ready, mem_src_sel, (c == 9), (c != 9), (c != 9));
            end
            if (v_req_valid && v_req_ready) b++;
            if (s_req_valid && s_req_ready) s_pend = 1'b0;
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (b != 20 || s_pend) begin
            errors++;
            $display("FAIL starve_done beats=%0d s_pend=%0b required 20 0", b, s_pend);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL starve_drain outstanding=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            v_req_valid = 1'b1; v_req_we = 1'b0; v_req_last = 1'b0;
            v_req_addr = 32'h200 + 32'(b) * 32'h20;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs some output=1 required all 0");
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({s_rsp_valid, v_rsp_valid, s_req_ready, v_req_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_quiet%0d s_rsp=%0b v_rsp=%0b required 0 0", c, s_rsp_valid, v_rsp_valid);
            end
        end
        @(posedge clk); #1;
        s_req_valid = 1'b1; s_req_addr = 32'h10;
        v_req_valid = 1'b1; v_req_addr = 32'h300; v_req_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_conflict s_rdy=%0b v_rdy=%0b required 1 0", s_req_ready, v_req_ready);
        end
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_req_ready, v_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_vgrant s_rdy=%0b v_rdy=%0b required 0 1", s_req_ready, v_req_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain outstanding=%0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_vburst();
        test_starvation();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
